// File: rtl/operand_sequencer_if.sv
// Handshake and operand bus between operand_sequencer and the LDH datapath.
// master: the sequencer (drives load/busy/readyR, operands, status).
// slave:  the datapath side (drives start/done, observes everything else).
interface operand_sequencer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 2
);
  logic             start;
  logic             done;
  logic             load;
  logic             busy;
  logic             readyR;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [IDX_W-1:0] vec_idx;
  logic             finished;
  logic             timeout_err;

  modport master (
    input  start, done,
    output load, busy, readyR, A, B, vec_idx, finished, timeout_err
  );

  modport slave (
    output start, done,
    input  load, busy, readyR, A, B, vec_idx, finished, timeout_err
  );
endinterface

// File: rtl/operand_sequencer.sv
// operand_sequencer: produces NUM_VECTORS operand pairs A/B from two LFSRs
// and drives the LDH datapath load/busy/readyR handshake for each pair.
// The strobes (load/busy/readyR) are registered copies of the FSM state, so
// they trail the state by one cycle; this gives operands one settled cycle
// before load rises. done is sampled while the FSM itself is in BUSY.
// Optional: define OPSEQ_TIMEOUT_EN to abort a BUSY phase that exceeds
// TIMEOUT_CYCLES cycles (sets the sticky timeout_err). Without it, BUSY
// waits indefinitely and timeout_err is tied low.
module operand_sequencer #(
  parameter int unsigned      WIDTH          = 8,
  parameter int unsigned      NUM_VECTORS    = 4,
  parameter logic [WIDTH-1:0] TAPS           = 8'hB8,
  parameter logic [WIDTH-1:0] SEED_A         = 8'hE9,
  parameter logic [WIDTH-1:0] SEED_B         = 8'hC3,
  parameter int unsigned      TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  operand_sequencer_if.master bus
);

  localparam int unsigned IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] SEED_A_EFF = (SEED_A == '0) ? ONE : SEED_A;
  localparam logic [WIDTH-1:0] SEED_B_EFF = (SEED_B == '0) ? ONE : SEED_B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BUSY,
    S_READY,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             load_q, busy_q, ready_q;
  logic             finished_q;
  logic             restart;
  logic             timeout_hit;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], ^(x & TAPS)};
  endfunction

`ifdef OPSEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             timeout_err_q;

  // Count completed BUSY cycles; the count is zero on the first BUSY cycle.
  always_comb begin
    busy_cnt_d = '0;
    if (state_q == S_BUSY) begin
      busy_cnt_d = busy_cnt_q + 1'b1;
    end
  end

  // Abort only when the last allowed BUSY cycle ends without done;
  // done on that same cycle still wins.
  assign timeout_hit = (state_q == S_BUSY) && !bus.done && (busy_cnt_q == CNT_LAST);

  // BUSY cycle counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cnt_q <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Sticky abort flag, cleared only by a restart or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_err_q <= 1'b0;
    end else if (restart) begin
      timeout_err_q <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Next-state logic plus operand/index updates tied to state transitions.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    restart = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (bus.done) begin
          state_d = S_READY;
        end else if (timeout_hit) begin
          state_d = S_FINISH;
        end
      end
      S_READY: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_LOAD;
          idx_d   = idx_q + 1'b1;
          a_d     = lfsr_step(a_q);
          b_d     = lfsr_step(b_q);
        end
      end
      S_FINISH: begin
        if (bus.start) begin
          state_d = S_LOAD;
          restart = 1'b1;
          a_d     = SEED_A_EFF;
          b_d     = SEED_B_EFF;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, operand and vector-index registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= SEED_A_EFF;
      b_q     <= SEED_B_EFF;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
    end
  end

  // Registered strobes: one-hot copies of the current state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      load_q  <= (state_q == S_LOAD);
      busy_q  <= (state_q == S_BUSY);
      ready_q <= (state_q == S_READY);
    end
  end

  // Sticky run-complete flag; a restart clears it on the restart edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      finished_q <= 1'b0;
    end else if (restart) begin
      finished_q <= 1'b0;
    end else if (state_q == S_FINISH) begin
      finished_q <= 1'b1;
    end
  end

  assign bus.load     = load_q;
  assign bus.busy     = busy_q;
  assign bus.readyR   = ready_q;
  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.vec_idx  = idx_q;
  assign bus.finished = finished_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer (default parameters).
// Stimulus pushes one expected record per vector; the monitor pops a record
// at every load strobe and checks busy length at the matching readyR.
module tb_operand_sequencer;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] idx;
    int         busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  operand_sequencer_if #(.WIDTH(8), .IDX_W(2)) bus ();

  operand_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Operand sequences worked by hand from next = {x[6:0], ^(x & 8'hB8)}.
  logic [7:0] a_tab [4] = '{8'hE9, 8'hD3, 8'hA6, 8'h4C};
  logic [7:0] b_tab [4] = '{8'hC3, 8'h87, 8'h0F, 8'h1F};

  exp_t exp_q[$];
  int   load_seen = 0;
  int   rdy_seen  = 0;
  int   busy_cnt  = 0;
  int   dp_k      = -1;  // -1: done held high, 0: never, k: done on k-th BUSY cycle
  int   dp_cnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Datapath model: drives done relative to the observed load strobe.
  always @(negedge clk) begin
    if (dp_k < 0) begin
      bus.done = 1'b1;
    end else if (dp_k == 0) begin
      bus.done = 1'b0;
    end else if (bus.load === 1'b1) begin
      dp_cnt   = 1;
      bus.done = (dp_k == 1);
    end else begin
      dp_cnt   = dp_cnt + 1;
      bus.done = (dp_cnt == dp_k);
    end
  end

  // Monitor: pops expectations on load, checks busy length on readyR.
  exp_t       cur;
  logic       pending = 1'b0;
  logic [7:0] prev_a  = 8'h00;
  logic [7:0] prev_b  = 8'h00;
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      busy_cnt = 0;
      pending  = 1'b0;
    end else begin
      if ((32'(bus.load) + 32'(bus.busy) + 32'(bus.readyR)) > 1) begin
        chk("strobe_exclusive", {29'd0, bus.load, bus.busy, bus.readyR}, 32'd0);
      end
      if (bus.load === 1'b1) begin
        load_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_load", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("load_A", bus.A, cur.a);
          chk("load_B", bus.B, cur.b);
          chk("load_idx", bus.vec_idx, cur.idx);
          chk("A_stable_before_load", prev_a, bus.A);
          chk("B_stable_before_load", prev_b, bus.B);
          pending  = 1'b1;
          busy_cnt = 0;
        end
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.readyR === 1'b1) begin
        rdy_seen++;
        if (!pending) begin
          chk("unexpected_readyR", 32'd1, 32'd0);
        end else begin
          chk("busy_len", busy_cnt, cur.busy);
          $display("txn vec=%0d A=%h B=%h busy=%0d", cur.idx, cur.a, cur.b, busy_cnt);
          pending = 1'b0;
        end
      end
    end
    prev_a = bus.A;
    prev_b = bus.B;
  end

  task automatic push_run(input int nvec, input int busy_len);
    exp_t e;
    for (int v = 0; v < nvec; v++) begin
      e.a    = a_tab[v];
      e.b    = b_tab[v];
      e.idx  = 2'(v);
      e.busy = busy_len;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_finished(input int budget);
    int n = 0;
    while (bus.finished !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("finished_within_budget", bus.finished, 1'b1);
  endtask

  task automatic check_end_of_run(input int rdy_base, input int n_rdy);
    chk("end_idx", bus.vec_idx, 2'd3);
    chk("end_A_held", bus.A, 8'h4C);
    chk("end_B_held", bus.B, 8'h1F);
    chk("readyR_count", rdy_seen - rdy_base, n_rdy);
    chk("queue_drained", exp_q.size(), 0);
    chk("no_timeout_err", bus.timeout_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rb;
    int n;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.done  = 1'b0;

    // Reset with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = 1'($urandom_range(0, 1));
    end
    chk("rst_load", bus.load, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_readyR", bus.readyR, 1'b0);
    chk("rst_A", bus.A, 8'hE9);
    chk("rst_B", bus.B, 8'hC3);
    chk("rst_idx", bus.vec_idx, 2'd0);
    chk("rst_finished", bus.finished, 1'b0);
    chk("rst_timeout_err", bus.timeout_err, 1'b0);
    bus.start = 1'b0;
    dp_k      = -1;
    @(negedge clk);
    reset = 1'b1;

    // done high in IDLE must not start anything.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ignores_done", bus.load, 1'b0);
    end

    // Run 1: done on the 2nd BUSY cycle.
    dp_k = 2;
    rb   = rdy_seen;
    push_run(4, 2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("latency_no_load_yet", bus.load, 1'b0);
    @(negedge clk);
    chk("latency_load", bus.load, 1'b1);
    wait_finished(200);
    check_end_of_run(rb, 4);

    // Run 2: restart from FINISH, done held high, start pulses mid-run.
    dp_k = -1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("finish_holds", {bus.finished, bus.load}, 2'b10);
    end
    rb = rdy_seen;
    push_run(4, 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("restart_A", bus.A, 8'hE9);
    chk("restart_B", bus.B, 8'hC3);
    chk("restart_idx", bus.vec_idx, 2'd0);
    chk("restart_finished", bus.finished, 1'b0);
    chk("restart_no_load_yet", bus.load, 1'b0);
    @(negedge clk);
    chk("restart_load", bus.load, 1'b1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.start = (c % 2 == 0) && (c < 7);
    end
    bus.start = 1'b0;
    wait_finished(200);
    check_end_of_run(rb, 4);

    // Run 3: asynchronous reset while the second vector is busy.
    dp_k = 3;
    n    = load_seen;
    push_run(2, 3);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rb = 0;
    while (load_seen < n + 2 && rb < 100) begin
      @(negedge clk);
      rb++;
    end
    chk("reached_vector1", load_seen >= n + 2, 1'b1);
    rb = 0;
    while (bus.busy !== 1'b1 && rb < 20) begin
      @(negedge clk);
      rb++;
    end
    chk("vector1_busy", bus.busy, 1'b1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_busy", bus.busy, 1'b0);
    chk("async_load_readyR", {bus.load, bus.readyR}, 2'b00);
    chk("async_A", bus.A, 8'hE9);
    chk("async_B", bus.B, 8'hC3);
    chk("async_idx", bus.vec_idx, 2'd0);
    chk("async_finished", bus.finished, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("reset_queue_drained", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_idle", {bus.load, bus.busy, bus.readyR}, 3'b000);
    end

`ifdef OPSEQ_TIMEOUT_EN
    // Run 4: done never arrives -> abort after 16 BUSY cycles.
    dp_k = 0;
    rb   = rdy_seen;
    push_run(1, 16);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_finished(100);
    chk("timeout_err_set", bus.timeout_err, 1'b1);
    chk("timeout_busy_len", busy_cnt, 16);
    chk("timeout_no_readyR", rdy_seen - rb, 0);

    // Run 5: done on the 16th BUSY cycle wins over the timeout.
    dp_k = 16;
    rb   = rdy_seen;
    push_run(4, 16);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("restart_clears_timeout", bus.timeout_err, 1'b0);
    wait_finished(400);
    check_end_of_run(rb, 4);
`else
    chk("timeout_err_tied", bus.timeout_err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
